// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: key FIFO read port and status between the PS/2 receiver and its consumer
interface ps2_rx_fifo_if #(parameter int FIFO_DEPTH = 8);
  logic                        rd_en;
  logic                        clr_err;
  logic [9:0]                  rd_data;
  logic                        empty;
  logic                        full;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic                        parity_err;
  logic                        frame_err;
  logic                        overflow;
  modport master (
    output rd_en, clr_err,
    input  rd_data, empty, full, count, parity_err, frame_err, overflow
  );
  modport slave (
    input  rd_en, clr_err,
    output rd_data, empty, full, count, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 frame receiver with E0/F0 prefix folding into a FWFT key FIFO
module ps2_rx_fifo #(
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_CYC   = 5000,
  parameter int FIFO_DEPTH    = 8,
  parameter int DECODE_PREFIX = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0]    clk_s, dat_s;
  logic          filt, fall;
  logic [FW-1:0] fcnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      filt  <= 1'b1;
      fall  <= 1'b0;
      fcnt  <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      fall  <= 1'b0;
      if (clk_s[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        fcnt <= '0;
        fall <= filt;
      end else fcnt <= fcnt + FW'(1);
    end
  end
  logic [1:0]    state;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic          par, ext, brk, push, pe, fe;
  logic [9:0]    push_d;
  logic [TW-1:0] tcnt;
  logic          d, timeout;
  assign d       = dat_s[1];
  assign timeout = state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      sh      <= '0;
      par     <= 1'b0;
      ext     <= 1'b0;
      brk     <= 1'b0;
      push    <= 1'b0;
      push_d  <= '0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      tcnt    <= '0;
    end else begin
      pe   <= 1'b0;
      fe   <= 1'b0;
      push <= 1'b0;
      tcnt <= (fall || state == IDLE) ? '0 : tcnt + TW'(1);
      if (timeout) begin
        state <= IDLE;
        fe    <= 1'b1;
        ext   <= 1'b0;
        brk   <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE: if (!d) begin
            state   <= DATA;
            bit_idx <= '0;
          end
          DATA: begin
            sh      <= {d, sh[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= d;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!d || !(^{sh, par})) begin
              fe  <= !d;
              pe  <= d;
              ext <= 1'b0;
              brk <= 1'b0;
            end else if (DECODE_PREFIX != 0 && sh == 8'hE0) ext <= 1'b1;
            else if (DECODE_PREFIX != 0 && sh == 8'hF0) brk <= 1'b1;
            else begin
              push   <= 1'b1;
              push_d <= DECODE_PREFIX != 0 ? {ext, brk, sh} : {2'b00, sh};
              ext    <= 1'b0;
              brk    <= 1'b0;
            end
          end
        endcase
      end
    end
  end
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    last;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          ovf, empty, full, do_pop, do_push;
  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(FIFO_DEPTH);
  assign do_pop  = bus.rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) if (do_push) mem[wp] <= push_d;
  // last keeps the most recently popped entry so rd_data is stable while empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      last <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) begin
        rp   <= rp + AW'(1);
        last <= mem[rp];
      end
      if (do_push != do_pop) cnt <= do_push ? cnt + (AW+1)'(1) : cnt - (AW+1)'(1);
      ovf <= (push && !do_push) || (ovf && !bus.clr_err);
    end
  end
  assign bus.rd_data    = empty ? last : mem[rp];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.count      = cnt;
  assign bus.overflow   = ovf;
  assign bus.parity_err = pe;
  assign bus.frame_err  = fe;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frame stimulus against hand-computed FIFO contents and error pulses
module tb_ps2_rx_fifo;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  int   n_chk = 0, n_fail = 0, pe_cyc = 0, fe_cyc = 0, pe0, fe0;
  ps2_rx_fifo_if #(.FIFO_DEPTH(8)) bus ();
  ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYC(5000), .FIFO_DEPTH(8), .DECODE_PREFIX(1)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.parity_err) pe_cyc++;
    if (bus.frame_err) fe_cyc++;
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end
  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  // pop_last pulses rd_en on the cycle the final fall's push lands in the FIFO
  task send_bits(input logic [10:0] f, input int n, input bit pop_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_last && i == n - 1) begin
        repeat (7) @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk) bus.rd_en = 1'b0;
        repeat (12) @(negedge clk);
      end else repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (20) @(negedge clk);
  endtask
  task send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit pop_push);
    logic p;
    p = ~^b ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11, pop_push);
  endtask
  task pop();
    @(negedge clk) bus.rd_en = 1'b1;
    @(negedge clk) bus.rd_en = 1'b0;
  endtask
  initial begin
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_errs", {bus.parity_err, bus.frame_err, bus.overflow}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h16, 0, 0, 0);
    check("b16_empty", bus.empty, 0);
    check("b16_count", bus.count, 1);
    check("b16_data", bus.rd_data, 10'h016);
    pop();
    check("pop_empty", bus.empty, 1);
    check("pop_count", bus.count, 0);
    check("pop_hold", bus.rd_data, 10'h016);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    check("prefix_nopush", bus.count, 0);
    send_frame(8'h5A, 0, 0, 0);
    check("ext_brk_count", bus.count, 1);
    check("ext_brk_data", bus.rd_data, 10'h35A);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1E, 0, 0, 0);
    check("brk_count", bus.count, 2);
    pop();
    check("brk_data", bus.rd_data, 10'h11E);
    pop();
    check("drain_empty", bus.empty, 1);
    pe0 = pe_cyc; fe0 = fe_cyc;
    send_frame(8'h55, 1, 0, 0);
    check("par_pulse", pe_cyc - pe0, 1);
    check("par_no_fe", fe_cyc - fe0, 0);
    check("par_count", bus.count, 0);
    pe0 = pe_cyc; fe0 = fe_cyc;
    send_frame(8'h55, 0, 1, 0);
    check("stop_pulse", fe_cyc - fe0, 1);
    check("stop_no_pe", pe_cyc - pe0, 0);
    check("stop_count", bus.count, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h55, 1, 0, 0);
    send_frame(8'h1E, 0, 0, 0);
    check("err_clr_flag", bus.rd_data, 10'h01E);
    pop();
    fe0 = fe_cyc;
    send_bits(11'b000_0011_1100, 5, 0);
    repeat (6000) @(negedge clk);
    check("timeout_pulse", fe_cyc - fe0, 1);
    check("timeout_nopush", bus.count, 0);
    send_frame(8'h1E, 0, 0, 0);
    check("after_to_count", bus.count, 1);
    check("after_to_data", bus.rd_data, 10'h01E);
    pop();
    for (int i = 0; i < 9; i++) send_frame(8'(8'h16 + i), 0, 0, 0);
    check("ovf_full", bus.full, 1);
    check("ovf_count", bus.count, 8);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_head", bus.rd_data, 10'h016);
    @(negedge clk) bus.clr_err = 1'b1;
    @(negedge clk) bus.clr_err = 1'b0;
    check("clr_ovf", bus.overflow, 0);
    check("clr_keep", bus.count, 8);
    send_frame(8'h2A, 0, 0, 1);
    check("pp_count", bus.count, 8);
    check("pp_full", bus.full, 1);
    check("pp_ovf", bus.overflow, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), bus.rd_data, i < 7 ? 32'(10'h017 + i) : 32'h02A);
      pop();
    end
    check("drain_all", bus.empty, 1);
    fe0 = fe_cyc;
    @(negedge clk) ps2_data = 1'b0;
    ps2_clk = 1'b0;
    @(negedge clk) ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2_data = 1'b1;
    repeat (6000) @(negedge clk);
    check("glitch_no_fe", fe_cyc - fe0, 0);
    send_frame(8'h16, 0, 0, 0);
    check("glitch_count", bus.count, 1);
    check("glitch_data", bus.rd_data, 10'h016);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver for the calculator datapath. It filters the PS/2 clock, deserialises 11-bit frames, and checks the start, odd-parity and stop bits. It optionally folds E0/F0 prefixes into extended and break flags, then buffers the decoded keys in a first-word-fall-through FIFO. The calculator control FSM pops keys through a rd_en handshake instead of sampling a single-cycle scan_ready pulse.

Parameters:
FILTER_LEN, 4, consecutive identical synchronised samples needed before the filtered PS/2 clock changes level (>=2)
TIMEOUT_CYC, 5000, clk cycles allowed between PS/2 falling edges inside a frame (100 us at 50 MHz)
FIFO_DEPTH, 8, FIFO entries; power of two, >=2
DECODE_PREFIX, 1, 1: absorb E0/F0 into flags; 0: every valid byte pushed raw with flags 0

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
rd_en  in  1  pop head entry
clr_err  in  1  clears sticky overflow
rd_data  out  10  head entry {ext, brk, code[7:0]}; valid while !empty
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH)+1  occupancy
parity_err  out  1  one-cycle pulse on bad parity
frame_err  out  1  one-cycle pulse on bad stop bit or timeout
overflow  out  1  sticky, set when a push is dropped

Behaviour:
- Reset (async, any state): FSM to IDLE, FIFO pointers and count to 0, ext/brk prefix flags cleared. Outputs: empty=1, full=0, count=0, rd_data=0, parity_err=0, frame_err=0, overflow=0. Filtered clock and both sync stages reset to 1.
- Input path: ps2_clk and ps2_data each pass through a 2-FF synchroniser. Filtered clock toggles only after FILTER_LEN equal samples of the opposite level. A falling edge is a 1->0 transition of the filtered clock, registered as a one-cycle fall strobe. Data is sampled on the fall strobe.
- FSM:
  - IDLE: on fall with data=0, go to DATA with bit index 0. On fall with data=1, stay in IDLE (spurious edge, no error).
  - DATA: shift data in LSB first. After 8 falls, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on fall, always return to IDLE.
    - If stop=0: pulse frame_err.
    - Else if XOR of 8 data bits and parity != 1: pulse parity_err.
    - Else the byte is valid.
- Timeout: counter clears on every fall strobe and increments while the FSM is not in IDLE. On reaching TIMEOUT_CYC: pulse frame_err, return to IDLE, discard the partial byte.
- Any error clears the ext/brk prefix flags.
- Valid byte, DECODE_PREFIX=1:
  - 0xE0 sets ext, no push.
  - 0xF0 sets brk, no push.
  - Any other byte pushes {ext, brk, byte} the cycle after the STOP fall, then clears both flags.
- Valid byte, DECODE_PREFIX=0: push {0, 0, byte}.
- FIFO:
  - Push latency: entry written 1 cycle after the STOP fall strobe; empty deasserts the following cycle.
  - rd_data is combinationally the head entry (FWFT). rd_data holds its last value when empty.
  - rd_en while empty: ignored.
  - Push while full with no pop: entry dropped, overflow set, pointers unchanged.
  - Push and pop in the same cycle: both performed, count unchanged. This applies when full too, with no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH).
- overflow stays set until clr_err=1 for one cycle. If clr_err and a new overflow coincide, overflow remains set.
- Errors never modify FIFO contents. parity_err and frame_err are mutually exclusive in a cycle.

Test Plan:
- Reset, then send frame 0x16 (parity 0) -> after stop: empty=0, count=1, rd_data=10'h016. Pulse rd_en -> empty=1, count=0.
- DECODE_PREFIX=1: send E0, F0, 0x5A -> exactly one entry rd_data=10'h35A (ext=1, brk=1), count=1. Send F0, 0x1E -> next entry 10'h11E.
- Send 0x55 with parity bit forced 0 -> one-cycle parity_err, count unchanged. Send 0x55 with stop bit 0 -> one-cycle frame_err, no push.
- Send start + 4 data bits, then hold ps2_clk high for 6000 cycles -> frame_err pulse at TIMEOUT_CYC. The next full frame 0x1E is received correctly as 10'h01E.
- FIFO_DEPTH=8: send 9 bytes 0x16..0x1E without reads -> full=1, count=8, overflow=1, head=0x016. Ninth byte lost. clr_err -> overflow=0.
- With full=1, assert rd_en on the push cycle of a new byte -> count stays 8, overflow stays 0. Add a 1-cycle ps2_clk glitch with FILTER_LEN=4 -> no bit is shifted.
